// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic, bit-serial shifts/rotates and an optional
// shift-add multiplier (op 11) that exists only when ALU_SEQ_MUL_EN is defined.
module alu_seq #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [3:0]    FuncOp,
    input  logic [N-1:0]  A,
    input  logic [N-1:0]  B,
    input  logic [SW-1:0] ShAmt,
    input  logic [3:0]    IFlags,
    input  logic          OE,
    output wire  [N-1:0]  Y,
    output logic [N-1:0]  YHi,
    output logic [3:0]    OFlags,
    output logic          Busy,
    output logic          Done
);

    localparam int CW = $clog2(N + 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SUBC = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_LSR  = 4'd7;
    localparam logic [3:0] OP_LSL  = 4'd8;
    localparam logic [3:0] OP_ASR  = 4'd9;
    localparam logic [3:0] OP_ROR  = 4'd10;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd11;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    op_r;
    logic [N-1:0]  a_r;
    logic [N-1:0]  y_r;
    logic          c_r;
    logic          v_r;
`ifdef ALU_SEQ_MUL_EN
    logic [N-1:0]  hi_r;
    logic [N-1:0]  mcand_r;
    logic [N-1:0]  yhi_r;
`endif

    logic unused_flags;
    assign unused_flags = ^{IFlags[3:2], IFlags[0]};

    // Flags {V,N,C,Z} for the logic ops: carry and overflow are always clear.
    function automatic logic [3:0] logic_flags(input logic [N-1:0] res);
        return {1'b0, res[N-1], 1'b0, res == '0};
    endfunction

    // Immediate path: result for everything that finishes on the Start edge.
    logic [N-1:0] addend;
    logic         add_cin;
    logic [N:0]   sum;
    logic [N-1:0] quick_y;
    logic [3:0]   quick_f;
    logic         quick_done;

    always_comb begin
        addend  = B;
        add_cin = IFlags[1];
        if (FuncOp == OP_SUB) begin
            addend  = ~B;
            add_cin = 1'b1;
        end else if (FuncOp == OP_SUBC) begin
            addend  = ~B;
            add_cin = ~IFlags[1];
        end
        sum = {1'b0, A} + {1'b0, addend} + {{N{1'b0}}, add_cin};

        quick_y    = '0;
        quick_f    = '0;
        quick_done = 1'b1;
        case (FuncOp)
            OP_ADD, OP_SUB, OP_SUBC: begin
                quick_y = sum[N-1:0];
                quick_f = {(A[N-1] == addend[N-1]) && (sum[N-1] != A[N-1]),
                           sum[N-1], sum[N], sum[N-1:0] == '0};
            end
            OP_AND: begin quick_y = A & B; quick_f = logic_flags(A & B); end
            OP_OR:  begin quick_y = A | B; quick_f = logic_flags(A | B); end
            OP_NOT: begin quick_y = ~A;    quick_f = logic_flags(~A);    end
            OP_XOR: begin quick_y = A ^ B; quick_f = logic_flags(A ^ B); end
            OP_LSR, OP_LSL, OP_ASR, OP_ROR: begin
                // Zero-length shift passes A and the incoming carry straight through.
                quick_y    = A;
                quick_f    = {1'b0, A[N-1], IFlags[1], A == '0};
                quick_done = (ShAmt == '0);
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: quick_done = 1'b0;
`endif
            default: ;
        endcase
    end

    // Serial path: one shift step or one shift-add multiply step per RUN cycle.
    logic [N-1:0] step_a;
    logic         step_c;
    logic         step_v;
`ifdef ALU_SEQ_MUL_EN
    logic [N-1:0] step_hi;
    logic [N:0]   psum;
`endif

    always_comb begin
        step_a = a_r;
        step_c = c_r;
        step_v = v_r;
`ifdef ALU_SEQ_MUL_EN
        step_hi = hi_r;
        psum    = '0;
`endif
        case (op_r)
            OP_LSR: begin step_a = {1'b0, a_r[N-1:1]};   step_c = a_r[0]; end
            OP_ASR: begin step_a = {a_r[N-1], a_r[N-1:1]}; step_c = a_r[0]; end
            OP_ROR: begin step_a = {c_r, a_r[N-1:1]};    step_c = a_r[0]; end
            OP_LSL: begin
                step_a = {a_r[N-2:0], 1'b0};
                step_c = a_r[N-1];
                step_v = v_r | (a_r[N-1] ^ a_r[N-2]);
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
                // a_r holds the multiplier in its low end and collects product bits from the top.
                psum    = {1'b0, hi_r} + (a_r[0] ? {1'b0, mcand_r} : '0);
                step_hi = psum[N:1];
                step_a  = {psum[0], a_r[N-1:1]};
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            cnt    <= '0;
            op_r   <= '0;
            a_r    <= '0;
            c_r    <= 1'b0;
            v_r    <= 1'b0;
            y_r    <= '0;
            OFlags <= '0;
`ifdef ALU_SEQ_MUL_EN
            hi_r    <= '0;
            mcand_r <= '0;
            yhi_r   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        op_r <= FuncOp;
                        a_r  <= A;
                        c_r  <= IFlags[1];
                        v_r  <= 1'b0;
                        cnt  <= CW'(ShAmt);
`ifdef ALU_SEQ_MUL_EN
                        hi_r    <= '0;
                        mcand_r <= A;
                        if (FuncOp == OP_MUL) begin
                            a_r <= B;
                            cnt <= CW'(N);
                        end
`endif
                        if (quick_done) begin
                            state  <= DONE;
                            Done   <= 1'b1;
                            y_r    <= quick_y;
                            OFlags <= quick_f;
`ifdef ALU_SEQ_MUL_EN
                            yhi_r  <= '0;
`endif
                        end else begin
                            state <= RUN;
                            Busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    a_r <= step_a;
                    c_r <= step_c;
                    v_r <= step_v;
                    cnt <= cnt - CW'(1);
`ifdef ALU_SEQ_MUL_EN
                    hi_r <= step_hi;
`endif
                    if (cnt == CW'(1)) begin
                        state  <= DONE;
                        Busy   <= 1'b0;
                        Done   <= 1'b1;
                        y_r    <= step_a;
                        OFlags <= {step_v, step_a[N-1], step_c, step_a == '0};
`ifdef ALU_SEQ_MUL_EN
                        if (op_r == OP_MUL) begin
                            yhi_r  <= step_hi;
                            OFlags <= {1'b0, step_hi[N-1], step_hi != '0, {step_hi, step_a} == '0};
                        end else begin
                            yhi_r <= '0;
                        end
`endif
                    end
                end
                DONE: begin
                    Done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Y = OE ? {N{1'bz}} : y_r;
`ifdef ALU_SEQ_MUL_EN
    assign YHi = yhi_r;
`else
    assign YHi = '0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (N=8): vector table through a scoreboard queue, plus hand-written
// sequences for Start-during-RUN, reset abort and output-enable behaviour.
`timescale 1ns/1ps
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       oe = 1'b0;
    logic [3:0] op = '0;
    logic [3:0] iflags = '0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] sh = '0;
    wire  [7:0] y;
    logic [7:0] yhi;
    logic [3:0] oflags;
    logic       busy;
    logic       done;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    alu_seq #(.N(8)) dut (
        .Clk(clk), .Reset(rst), .Start(start), .FuncOp(op), .A(a), .B(b), .ShAmt(sh),
        .IFlags(iflags), .OE(oe), .Y(y), .YHi(yhi), .OFlags(oflags), .Busy(busy), .Done(done)
    );

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sh;
        logic       cin;
        logic [7:0] y;
        logic [7:0] hi;
        logic [3:0] f;
        int         busy;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb,
                       input logic [2:0] s, input logic c, input logic [7:0] ey,
                       input logic [7:0] ehi, input logic [3:0] ef, input int eb);
        vec_t v;
        v.op = o; v.a = va; v.b = vb; v.sh = s; v.cin = c;
        v.y = ey; v.hi = ehi; v.f = ef; v.busy = eb;
        tbl.push_back(v);
    endtask

    task automatic wait_done(output int nbusy, output bit got);
        nbusy = 0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        vec_t e;
        int   nb;
        bit   got;
        @(negedge clk);
        op = v.op; a = v.a; b = v.b; sh = v.sh;
        iflags = {2'b10, v.cin, 1'b1};
        start = 1'b1;
        sb.push_back(v);
        @(negedge clk);
        start = 1'b0;
        wait_done(nb, got);
        e = sb.pop_front();
        check($sformatf("v%0d_done_seen", idx), 32'(got), 32'd1);
        if (got) begin
            check($sformatf("v%0d_y", idx), 32'(y), 32'(e.y));
            check($sformatf("v%0d_yhi", idx), 32'(yhi), 32'(e.hi));
            check($sformatf("v%0d_flags", idx), 32'(oflags), 32'(e.f));
            check($sformatf("v%0d_busy_cycles", idx), 32'(nb), 32'(e.busy));
            @(negedge clk);
            check($sformatf("v%0d_done_single", idx), 32'(done), 32'd0);
            check($sformatf("v%0d_y_hold", idx), 32'(y), 32'(e.y));
        end
    endtask

    initial begin
        int  nb;
        bit  got;
        bit  ghost;
        vec_t lv;

        //  op  A      B      sh cin  Y      YHi    {V,N,C,Z} busy
        add(0, 8'h7F, 8'h01, 0, 0, 8'h80, 8'h00, 4'b1100, 0);
        add(0, 8'hFF, 8'h01, 0, 0, 8'h00, 8'h00, 4'b0011, 0);
        add(0, 8'h10, 8'h20, 0, 1, 8'h31, 8'h00, 4'b0000, 0);
        add(1, 8'h05, 8'h07, 0, 0, 8'hFE, 8'h00, 4'b0100, 0);
        add(1, 8'h80, 8'h01, 0, 1, 8'h7F, 8'h00, 4'b1010, 0);
        add(2, 8'h10, 8'h05, 0, 1, 8'h0A, 8'h00, 4'b0010, 0);
        add(2, 8'h05, 8'h05, 0, 0, 8'h00, 8'h00, 4'b0011, 0);
        add(3, 8'hF0, 8'h3C, 0, 1, 8'h30, 8'h00, 4'b0000, 0);
        add(4, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 4'b0001, 0);
        add(5, 8'h0F, 8'hAA, 0, 0, 8'hF0, 8'h00, 4'b0100, 0);
        add(6, 8'hAA, 8'h55, 0, 0, 8'hFF, 8'h00, 4'b0100, 0);
        add(8, 8'h41, 8'h00, 2, 0, 8'h04, 8'h00, 4'b1010, 2);
        add(8, 8'h80, 8'h00, 1, 0, 8'h00, 8'h00, 4'b1011, 1);
        add(7, 8'h81, 8'h00, 1, 0, 8'h40, 8'h00, 4'b0010, 1);
`ifdef ALU_SEQ_MUL_EN
        add(11, 8'hFF, 8'hFF, 0, 0, 8'h01, 8'hFE, 4'b0110, 8);
        add(11, 8'h0D, 8'h0B, 0, 0, 8'h8F, 8'h00, 4'b0000, 8);
`else
        add(11, 8'hFF, 8'hFF, 0, 0, 8'h00, 8'h00, 4'b0000, 0);
        add(11, 8'h0D, 8'h0B, 0, 0, 8'h00, 8'h00, 4'b0000, 0);
`endif
        add(10, 8'h01, 8'h00, 2, 1, 8'hC0, 8'h00, 4'b0100, 2);
        add(7, 8'h80, 8'h00, 0, 1, 8'h80, 8'h00, 4'b0110, 0);
        add(9, 8'h80, 8'h00, 7, 0, 8'hFF, 8'h00, 4'b0100, 7);
        add(12, 8'hFF, 8'hFF, 3, 1, 8'h00, 8'h00, 4'b0000, 0);
        add(15, 8'h01, 8'h01, 0, 0, 8'h00, 8'h00, 4'b0000, 0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_yhi", 32'(yhi), 32'd0);
        check("rst_flags", 32'(oflags), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

        // Start and operand changes during RUN must be ignored
        @(negedge clk);
        op = 4'd9; a = 8'h80; sh = 3'd7; iflags = 4'b0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 8'h01; op = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(nb, got);
        check("asr_done_seen", 32'(got), 32'd1);
        check("asr_y", 32'(y), 32'hFF);
        check("asr_flags", 32'(oflags), 32'(4'b0100));
        check("asr_busy_rest", 32'(nb), 32'd5);
        ghost = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) ghost = 1'b1;
        end
        check("asr_start_ignored", 32'(ghost), 32'd0);

        // Reset abort of a long operation
        run_vec(tbl[0], 100);
        @(negedge clk);
`ifdef ALU_SEQ_MUL_EN
        op = 4'd11; a = 8'hFF; b = 8'hFF; sh = 3'd0;
`else
        op = 4'd9; a = 8'h80; b = 8'h00; sh = 3'd7;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_y", 32'(y), 32'd0);
        check("abort_yhi", 32'(yhi), 32'd0);
        check("abort_flags", 32'(oflags), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ghost = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) ghost = 1'b1;
        end
        check("abort_no_done", 32'(ghost), 32'd0);

        // Output enable: Y released while OE=1, flags unaffected
        lv = tbl[0];
        run_vec(lv, 101);
        @(negedge clk);
        oe = 1'b1;
        #1;
        total++;
        if (y === 8'h80) begin
            bad++;
            $display("FAIL oe_release: got %0h required high-impedance", y);
        end
        check("oe_flags", 32'(oflags), 32'(4'b1100));
        @(negedge clk);
        oe = 1'b0;
        #1;
        check("oe_restore_y", 32'(y), 32'h80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter: N, 8, datapath width in bits (legal 4..32).
REQ-002 SHALL have parameter: SW, $clog2(N), width of shift-amount port (derived, not overridden).
REQ-003 SHALL have port: Clk  input  1  rising-edge clock.
REQ-004 SHALL have port: Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: Start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port: FuncOp  input  4  operation code.
REQ-007 SHALL have ports: A, B  input  N  operands; ShAmt  input  SW  shift count.
REQ-008 SHALL have port: IFlags  input  4  incoming flags {V,N,C,Z}; only C (bit 1) is used.
REQ-009 SHALL have port: Y  output  N  result, tri-stated when OE=1.
REQ-010 SHALL have ports: YHi  output  N  multiply high half; OFlags  output  4  {V,N,C,Z}.
REQ-011 SHALL have ports: OE  input  1  active-low output enable; Busy  output  1; Done  output  1.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; Busy=1 in RUN only.
REQ-013 SHALL, in IDLE with Start=1, latch A, B, ShAmt, FuncOp, IFlags[1] into internal registers; later input changes SHALL not affect the operation.
REQ-014 SHALL use op codes: 0 Add(A+B+Cin), 1 Sub(A+~B+1), 2 Subc(Cin=0: A+~B+1; Cin=1: A+~B), 3 And, 4 Or, 5 Not(~A), 6 Xor, 7 Lsr A, 8 Lsl A, 9 Asr A, 10 Ror A through C, 11 Mul A*B unsigned; 12-15 illegal.
REQ-015 SHALL complete ops 0-6 in one cycle: IDLE -> DONE on the Start edge; result visible the following cycle.
REQ-016 SHALL perform shifts/rotates one bit per cycle in RUN for ShAmt cycles; ShAmt=0 SHALL go IDLE -> DONE with Y=A, C=Cin, V=0.
REQ-017 SHALL perform Mul as shift-add, exactly N cycles in RUN; {YHi,Y}=A*B.
REQ-018 SHALL assert Done for exactly one cycle in DONE, then return to IDLE; Y, YHi, OFlags SHALL hold until the next accepted Start.
REQ-019 SHALL ignore Start while in RUN or DONE (no queueing).
REQ-020 Flags: Z = (Y==0) (Mul: {YHi,Y}==0); N = Y[N-1] (Mul: YHi[N-1]).
REQ-021 C: carry-out for Add/Sub/Subc; last bit shifted out for shifts/rotates; (YHi!=0) for Mul; 0 for logic ops.
REQ-022 V: signed overflow (operand signs equal, result sign differs) for Add/Sub/Subc; for Lsl, sticky OR over steps of (MSB xor next-MSB) before each step; 0 for all others.
REQ-023 Illegal op SHALL go IDLE -> DONE with Y=0, YHi=0, OFlags=4'b0000.
REQ-024 Y SHALL equal {N{1'bz}} whenever OE=1, independent of state; YHi and OFlags are never tri-stated.

Reset
REQ-025 Reset=1 SHALL asynchronously force IDLE, Busy=0, Done=0, Y register=0, YHi=0, OFlags=0, counters=0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation; no Done pulse SHALL follow reset release.

Configuration
REQ-027 Macro ALU_SEQ_MUL_EN defined: op 11 SHALL behave per REQ-017; undefined: op 11 SHALL be treated as illegal (REQ-023) and no multiplier registers SHALL be synthesised, YHi tied to 0.

Verification
REQ-028 N=8, Add A=0x7F B=0x01 Cin=0, Start -> Done next cycle, Y=0x80, OFlags V=1 N=1 C=0 Z=0.
REQ-029 N=8, Lsl A=0x41 ShAmt=2 -> Busy 2 cycles, Y=0x04, C=1, V=1, Done single pulse.
REQ-030 N=8, Mul A=0xFF B=0xFF with ALU_SEQ_MUL_EN -> 8 Busy cycles, YHi=0xFE, Y=0x01, C=1; without macro -> 1 cycle, Y=0, OFlags=0.
REQ-031 Asr A=0x80 ShAmt=7, change A and pulse Start during RUN -> Y=0xFF, C=0, second Start ignored.
REQ-032 Reset pulse at 3rd cycle of Mul -> Busy=0, Y=0, no Done afterwards; OE=1 at any time -> Y=Z.
